video_line_fetcher: RTL and testbench

- Successor to the CGIA fetch-start logic.
- On each displayed scanline it runs a parametrised burst of Wishbone classic master reads from video memory and writes the returned words into the CGIA line buffer.
- Tracks a per-frame line pointer that reloads on VSYNC and advances by a programmable stride per line.
- Flags overrun when the CRTC requests a new line before the previous fetch completes.

---
 rtl/video_line_fetcher.sv | 181 ++++++++++++++++++
 tb/tb_video_line_fetcher.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_line_fetcher.sv
// Per-scanline Wishbone burst reader that fills the CGIA line buffer from a
// strided frame pointer. Optional bank ping-pong via VIDEO_LINE_FETCHER_DOUBLE_BUFFER_EN.
module video_line_fetcher #(
    parameter int ADDR_W     = 23,
    parameter int DATA_W     = 16,
    parameter int LINE_WORDS = 40,
    parameter int BUF_AW     = 6
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              hsync_i,
    input  logic              den_i,
    input  logic              vsync_i,
    input  logic [ADDR_W-1:0] base_i,
    input  logic [ADDR_W-1:0] stride_i,
    output logic              cyc_o,
    output logic              stb_o,
    output logic              we_o,
    output logic [ADDR_W-1:0] adr_o,
    input  logic [DATA_W-1:0] dat_i,
    input  logic              ack_i,
    output logic              buf_we_o,
    output logic [BUF_AW-1:0] buf_adr_o,
    output logic [DATA_W-1:0] buf_dat_o,
    output logic              buf_bank_o,
    output logic              busy_o,
    output logic              overrun_o
);

    typedef enum logic {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    localparam logic [BUF_AW-1:0] LAST_WORD = BUF_AW'(LINE_WORDS - 1);

    state_t            state_q, state_d;
    logic              hsync_q;
    logic              vsync_q;
    logic [ADDR_W-1:0] line_ptr_q, line_ptr_d;
    logic              reload_pend_q, reload_pend_d;
    logic [BUF_AW-1:0] count_q, count_d;
    logic              cyc_q, cyc_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic              buf_we_q, buf_we_d;
    logic [BUF_AW-1:0] buf_adr_q, buf_adr_d;
    logic [DATA_W-1:0] buf_dat_q, buf_dat_d;
    logic              overrun_q, overrun_d;
    logic [ADDR_W-1:0] fetch_base;
    logic              start;
    logic              vs_rise;

    assign start   = hsync_i & ~hsync_q & den_i;
    assign vs_rise = vsync_i & ~vsync_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q       <= IDLE;
            hsync_q       <= 1'b0;
            vsync_q       <= 1'b0;
            line_ptr_q    <= '0;
            reload_pend_q <= 1'b1;
            count_q       <= '0;
            cyc_q         <= 1'b0;
            adr_q         <= '0;
            buf_we_q      <= 1'b0;
            buf_adr_q     <= '0;
            buf_dat_q     <= '0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            hsync_q       <= hsync_i;
            vsync_q       <= vsync_i;
            line_ptr_q    <= line_ptr_d;
            reload_pend_q <= reload_pend_d;
            count_q       <= count_d;
            cyc_q         <= cyc_d;
            adr_q         <= adr_d;
            buf_we_q      <= buf_we_d;
            buf_adr_q     <= buf_adr_d;
            buf_dat_q     <= buf_dat_d;
            overrun_q     <= overrun_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        line_ptr_d    = line_ptr_q;
        reload_pend_d = reload_pend_q;
        count_d       = count_q;
        cyc_d         = cyc_q;
        adr_d         = adr_q;
        buf_we_d      = 1'b0;
        buf_adr_d     = buf_adr_q;
        buf_dat_d     = buf_dat_q;
        overrun_d     = overrun_q;
        fetch_base    = line_ptr_q;

        case (state_q)
            IDLE: begin
                // A pending reload takes effect in the same clock a line may start.
                if (reload_pend_q) begin
                    fetch_base    = base_i;
                    line_ptr_d    = base_i;
                    reload_pend_d = 1'b0;
                end
                if (start) begin
                    state_d = FETCH;
                    count_d = '0;
                    cyc_d   = 1'b1;
                    adr_d   = fetch_base;
                end
            end
            FETCH: begin
                if (start) begin
                    overrun_d = 1'b1;
                end
                if (ack_i) begin
                    buf_we_d  = 1'b1;
                    buf_adr_d = count_q;
                    buf_dat_d = dat_i;
                    count_d   = count_q + 1'b1;
                    adr_d     = adr_q + 1'b1;
                    if (count_q == LAST_WORD) begin
                        cyc_d   = 1'b0;
                        state_d = IDLE;
                        // A deferred reload overwrites the pointer on return to IDLE.
                        if (!reload_pend_q && !vs_rise) begin
                            line_ptr_d = line_ptr_q + stride_i;
                        end
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (vs_rise) begin
            reload_pend_d = 1'b1;
            overrun_d     = 1'b0;
        end
    end

`ifdef VIDEO_LINE_FETCHER_DOUBLE_BUFFER_EN
    logic bank_q, bank_d;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            bank_q <= 1'b0;
        end else begin
            bank_q <= bank_d;
        end
    end

    // Flip on the clock the bus cycle ends so the next line lands in the other bank.
    always_comb begin
        bank_d = bank_q;
        if (vs_rise) begin
            bank_d = 1'b0;
        end else if (state_q == FETCH && ack_i && count_q == LAST_WORD) begin
            bank_d = ~bank_q;
        end
    end

    assign buf_bank_o = bank_q;
`else
    assign buf_bank_o = 1'b0;
`endif

    assign cyc_o     = cyc_q;
    assign stb_o     = cyc_q;
    assign busy_o    = cyc_q;
    assign we_o      = 1'b0;
    assign adr_o     = adr_q;
    assign buf_we_o  = buf_we_q;
    assign buf_adr_o = buf_adr_q;
    assign buf_dat_o = buf_dat_q;
    assign overrun_o = overrun_q;

endmodule

// File: tb/tb_video_line_fetcher.sv
// Randomised self-checking bench for video_line_fetcher; the reference model
// tracks frame pointer, overrun and bank state as plain per-line arithmetic.
module tb_video_line_fetcher;

    localparam int ADDR_W     = 23;
    localparam int DATA_W     = 16;
    localparam int LINE_WORDS = 40;
    localparam int BUF_AW     = 6;

    logic              clk_i = 1'b0;
    logic              reset_i = 1'b1;
    logic              hsync_i = 1'b0;
    logic              den_i = 1'b0;
    logic              vsync_i = 1'b0;
    logic [ADDR_W-1:0] base_i = '0;
    logic [ADDR_W-1:0] stride_i = '0;
    logic              cyc_o;
    logic              stb_o;
    logic              we_o;
    logic [ADDR_W-1:0] adr_o;
    logic [DATA_W-1:0] dat_i = '0;
    logic              ack_i = 1'b0;
    logic              buf_we_o;
    logic [BUF_AW-1:0] buf_adr_o;
    logic [DATA_W-1:0] buf_dat_o;
    logic              buf_bank_o;
    logic              busy_o;
    logic              overrun_o;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [ADDR_W-1:0] model_ptr;
    logic              model_overrun;
    logic              model_bank;

    video_line_fetcher #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .LINE_WORDS(LINE_WORDS),
        .BUF_AW    (BUF_AW)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .hsync_i   (hsync_i),
        .den_i     (den_i),
        .vsync_i   (vsync_i),
        .base_i    (base_i),
        .stride_i  (stride_i),
        .cyc_o     (cyc_o),
        .stb_o     (stb_o),
        .we_o      (we_o),
        .adr_o     (adr_o),
        .dat_i     (dat_i),
        .ack_i     (ack_i),
        .buf_we_o  (buf_we_o),
        .buf_adr_o (buf_adr_o),
        .buf_dat_o (buf_dat_o),
        .buf_bank_o(buf_bank_o),
        .busy_o    (busy_o),
        .overrun_o (overrun_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic bank_after_line(input logic b);
`ifdef VIDEO_LINE_FETCHER_DOUBLE_BUFFER_EN
        return ~b;
`else
        return b;
`endif
    endfunction

    task automatic test_reset;
        reset_i = 1'b1;
        base_i   = 23'h001000;
        stride_i = 23'd40;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({cyc_o, stb_o, we_o, buf_we_o, buf_bank_o, busy_o, overrun_o} !== 7'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 0000000",
                     {cyc_o, stb_o, we_o, buf_we_o, buf_bank_o, busy_o, overrun_o});
        end
        checks++;
        if (adr_o !== '0 || buf_adr_o !== '0 || buf_dat_o !== '0) begin
            errors++;
            $display("[TB] FAIL reset_buses: got adr=%h badr=%h bdat=%h expected 0",
                     adr_o, buf_adr_o, buf_dat_o);
        end
        reset_i = 1'b0;
        model_ptr     = base_i;
        model_overrun = 1'b0;
        model_bank    = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic vsync_pulse;
        vsync_i = 1'b1;
        @(negedge clk_i);
        vsync_i = 1'b0;
        model_ptr     = base_i;
        model_overrun = 1'b0;
        model_bank    = 1'b0;
        @(negedge clk_i);
        checks++;
        if (overrun_o !== 1'b0 || buf_bank_o !== 1'b0) begin
            errors++;
            $display("[TB] FAIL vsync_clear: got ovr=%b bank=%b expected 0 0", overrun_o, buf_bank_o);
        end
    endtask

    // wait_mode: 0 = ack every clock, 1 = ack every 3rd clock, 2 = random acks
    task automatic run_line(input int wait_mode, input int ovr_at, input int vs_at, input int rst_at);
        logic [ADDR_W-1:0] start_adr;
        logic [DATA_W-1:0] exp_dat;
        logic              exp_we;
        logic              defer;
        int                exp_idx;
        int                k;
        int                cycles;
        bit                ack;
        start_adr = model_ptr;
        defer     = 1'b0;
        exp_we    = 1'b0;
        exp_idx   = 0;
        exp_dat   = '0;
        k         = 0;
        cycles    = 0;
        den_i     = 1'b1;
        hsync_i   = 1'b1;
        @(negedge clk_i);
        hsync_i = 1'b0;
        forever begin
            if (k < LINE_WORDS) begin
                checks++;
                if (cyc_o !== 1'b1 || stb_o !== 1'b1 || busy_o !== 1'b1 || we_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL bus_active word %0d: got cyc/stb/busy/we=%b%b%b%b expected 1110",
                             k, cyc_o, stb_o, busy_o, we_o);
                end
                checks++;
                if (adr_o !== start_adr + ADDR_W'(k)) begin
                    errors++;
                    $display("[TB] FAIL adr_o word %0d: got %h expected %h", k, adr_o, start_adr + ADDR_W'(k));
                end
            end else begin
                checks++;
                if (cyc_o !== 1'b0 || stb_o !== 1'b0 || busy_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL bus_release: got cyc/stb/busy=%b%b%b expected 000", cyc_o, stb_o, busy_o);
                end
            end
            checks++;
            if (buf_we_o !== exp_we) begin
                errors++;
                $display("[TB] FAIL buf_we_o: got %b expected %b", buf_we_o, exp_we);
            end else if (exp_we) begin
                checks++;
                if (buf_adr_o !== BUF_AW'(exp_idx) || buf_dat_o !== exp_dat) begin
                    errors++;
                    $display("[TB] FAIL buf_write: got adr=%0d dat=%h expected adr=%0d dat=%h",
                             buf_adr_o, buf_dat_o, exp_idx, exp_dat);
                end
            end
            checks++;
            if (overrun_o !== model_overrun || buf_bank_o !== model_bank) begin
                errors++;
                $display("[TB] FAIL status: got ovr=%b bank=%b expected ovr=%b bank=%b",
                         overrun_o, buf_bank_o, model_overrun, model_bank);
            end
            if (k >= LINE_WORDS) break;
            if (cycles > 1000) begin
                errors++;
                $display("[TB] FAIL line_timeout: got %0d words expected %0d", k, LINE_WORDS);
                break;
            end

            hsync_i = 1'b0;
            vsync_i = 1'b0;
            exp_we  = 1'b0;
            if (k == rst_at) begin
                ack_i   = 1'b0;
                reset_i = 1'b1;
                #1;
                checks++;
                if (cyc_o !== 1'b0 || stb_o !== 1'b0 || busy_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL async_reset: got cyc/stb/busy=%b%b%b expected 000", cyc_o, stb_o, busy_o);
                end
                repeat (2) begin
                    @(negedge clk_i);
                    checks++;
                    if (buf_we_o !== 1'b0 || cyc_o !== 1'b0) begin
                        errors++;
                        $display("[TB] FAIL reset_hold: got we=%b cyc=%b expected 0 0", buf_we_o, cyc_o);
                    end
                end
                reset_i = 1'b0;
                @(negedge clk_i);
                checks++;
                if (buf_we_o !== 1'b0 || cyc_o !== 1'b0 || adr_o !== '0 || overrun_o !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL reset_release: got we=%b cyc=%b adr=%h ovr=%b expected 0 0 0 0",
                             buf_we_o, cyc_o, adr_o, overrun_o);
                end
                model_ptr     = base_i;
                model_overrun = 1'b0;
                model_bank    = 1'b0;
                return;
            end
            if (k == ovr_at && ovr_at >= 0) begin
                hsync_i       = 1'b1;
                model_overrun = 1'b1;
                ovr_at        = -1;
            end
            if (k == vs_at && vs_at >= 0) begin
                vsync_i       = 1'b1;
                model_overrun = 1'b0;
                model_bank    = 1'b0;
                defer         = 1'b1;
                vs_at         = -1;
            end
            case (wait_mode)
                0:       ack = 1'b1;
                1:       ack = (cycles % 3) == 2;
                default: ack = $urandom_range(0, 1) == 1;
            endcase
            ack_i = ack;
            dat_i = DATA_W'($urandom);
            if (ack) begin
                exp_we  = 1'b1;
                exp_idx = k;
                exp_dat = dat_i;
                k++;
                if (k == LINE_WORDS) model_bank = bank_after_line(model_bank);
            end
            cycles++;
            @(negedge clk_i);
        end
        ack_i     = 1'b0;
        model_ptr = defer ? base_i : model_ptr + stride_i;
    endtask

    task automatic test_basic_line;
        vsync_pulse();
        run_line(0, -1, -1, -1);
        run_line(0, -1, -1, -1);
        vsync_pulse();
        run_line(0, -1, -1, -1);
    endtask

    task automatic test_wait_states;
        run_line(1, -1, -1, -1);
    endtask

    task automatic test_random_lines;
        for (int i = 0; i < 4; i++) begin
            base_i   = (i == 0) ? 23'h7FFFF0 : ADDR_W'($urandom);
            stride_i = ADDR_W'($urandom_range(0, 300));
            vsync_pulse();
            run_line(2, -1, -1, -1);
            run_line(2, -1, -1, -1);
        end
    endtask

    task automatic test_overrun;
        run_line(2, 20, -1, -1);
        repeat (3) @(negedge clk_i);
        checks++;
        if (overrun_o !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_sticky: got %b expected 1", overrun_o);
        end
        vsync_pulse();
    endtask

    task automatic test_vsync_mid_fetch;
        run_line(0, -1, 15, -1);
        run_line(0, -1, -1, -1);
    endtask

    task automatic test_no_den;
        den_i   = 1'b0;
        hsync_i = 1'b1;
        repeat (2) @(negedge clk_i);
        hsync_i = 1'b0;
        ack_i   = 1'b1;
        repeat (4) begin
            @(negedge clk_i);
            checks++;
            if (cyc_o !== 1'b0 || buf_we_o !== 1'b0) begin
                errors++;
                $display("[TB] FAIL no_den_idle: got cyc=%b we=%b expected 0 0", cyc_o, buf_we_o);
            end
        end
        ack_i = 1'b0;
        den_i = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_reset_mid_burst;
        run_line(0, -1, -1, 10);
        run_line(0, -1, -1, -1);
    endtask

    task automatic test_bank;
        vsync_pulse();
        for (int i = 0; i < 3; i++) run_line(2, -1, -1, -1);
        vsync_pulse();
    endtask

    initial begin
        $display("[TB] start");
        test_reset();
        test_basic_line();
        test_wait_states();
        test_random_lines();
        base_i   = 23'h001000;
        stride_i = 23'd40;
        vsync_pulse();
        test_overrun();
        test_vsync_mid_fetch();
        test_no_den();
        test_reset_mid_burst();
        test_bank();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
